// File: rtl/inner_ebi_link.sv
// rtl/inner_ebi_link.sv - cache-side EBI link: frames requests onto 16-bit half-duplex pins and deframes responses
module inner_ebi_link #(
  parameter int EBI_WIDTH        = 16,
  parameter int PADDR_WIDTH      = 32,
  parameter int CACHELINE_LENGTH = 512,
  parameter int TX_BUF_LENGTH    = PADDR_WIDTH + EBI_WIDTH + CACHELINE_LENGTH,
  parameter int RX_BUF_LENGTH    = CACHELINE_LENGTH + EBI_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [EBI_WIDTH-1:0]     ebi_o,
  input  logic [EBI_WIDTH-1:0]     ebi_i,
  output logic [EBI_WIDTH-1:0]     ebi_oen,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [3:0]               tx_opcode,
  input  logic [TX_BUF_LENGTH-1:0] tx_data,
  output logic                     tx_done,
  output logic                     rx_valid,
  output logic [3:0]               rx_opcode,
  output logic [RX_BUF_LENGTH-1:0] rx_data,
  output logic                     rx_err,
  output logic                     busy
);
  localparam int RX_WORDS = RX_BUF_LENGTH / EBI_WIDTH;
  localparam logic [EBI_WIDTH-1:0] START_WORD = {{(EBI_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [EBI_WIDTH-1:0] STOP_WORD  = '1;
  localparam logic [EBI_WIDTH-1:0] OP_RD_RESP = EBI_WIDTH'(7);
  localparam logic [EBI_WIDTH-1:0] OP_SNP_REQ = EBI_WIDTH'(6);

  typedef enum logic [2:0] {T_IDLE, T_START, T_OP, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_OP, R_DATA, R_STOP} rx_state_t;

  tx_state_t              tx_state;
  rx_state_t              rx_state;
  logic [EBI_WIDTH-1:0]   rff;
  logic [TX_BUF_LENGTH-1:0] tx_buf;
  logic [3:0]             tx_op;
  logic [5:0]             tx_n;
  logic [5:0]             tx_cnt;
  logic [5:0]             rx_n;
  logic [5:0]             rx_cnt;

  function automatic logic [5:0] tx_len(input logic [3:0] op);
    case (op)
      4'd0:    tx_len = 6'd4;
      4'd1:    tx_len = 6'd35;
      4'd2:    tx_len = 6'd3;
      4'd3:    tx_len = 6'd32;
      default: tx_len = 6'd0;
    endcase
  endfunction

  assign tx_ready = (tx_state == T_IDLE) && (rx_state == R_IDLE) && rff[0];
  assign busy     = (tx_state != T_IDLE) || (rx_state != R_IDLE);

  // Pin outputs are loaded with the word belonging to the state being entered,
  // so each state name matches what is currently on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      ebi_o    <= '1;
      ebi_oen  <= '1;
      tx_done  <= 1'b0;
      tx_buf   <= '0;
      tx_op    <= 4'd0;
      tx_n     <= 6'd0;
      tx_cnt   <= 6'd0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_buf <= tx_data;
            tx_op  <= tx_opcode;
            tx_n   <= tx_len(tx_opcode);
            // Unknown opcodes complete the handshake but never touch the pins.
            if (tx_opcode <= 4'd4) begin
              tx_state <= T_START;
              ebi_o    <= START_WORD;
              ebi_oen  <= '0;
            end
          end
        end
        T_START: begin
          ebi_o    <= {{(EBI_WIDTH-4){1'b0}}, tx_op};
          tx_state <= T_OP;
        end
        T_OP: begin
          if (tx_n == 6'd0) begin
            ebi_o    <= STOP_WORD;
            tx_state <= T_STOP;
          end else begin
            ebi_o    <= tx_buf[EBI_WIDTH-1:0];
            tx_buf   <= tx_buf >> EBI_WIDTH;
            tx_cnt   <= 6'd1;
            tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_cnt == tx_n) begin
            ebi_o    <= STOP_WORD;
            tx_state <= T_STOP;
          end else begin
            ebi_o  <= tx_buf[EBI_WIDTH-1:0];
            tx_buf <= tx_buf >> EBI_WIDTH;
            tx_cnt <= tx_cnt + 6'd1;
          end
        end
        T_STOP: begin
          ebi_o    <= '1;
          ebi_oen  <= '1;
          tx_done  <= 1'b1;
          tx_state <= T_IDLE;
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rff       <= '1;
      rx_state  <= R_IDLE;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      rx_opcode <= 4'd0;
      rx_data   <= '0;
      rx_n      <= 6'd0;
      rx_cnt    <= 6'd0;
    end else begin
      rff      <= ebi_i;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          // Our own transmission echoes back on rff; only listen when TX is quiet.
          if (!rff[0] && tx_state == T_IDLE) rx_state <= R_OP;
        end
        R_OP: begin
          rx_state <= R_IDLE;
          if (rff == OP_RD_RESP || rff == OP_SNP_REQ) begin
            rx_opcode <= rff[3:0];
            rx_data   <= '0;
            rx_n      <= (rff == OP_RD_RESP) ? 6'd33 : 6'd3;
            rx_cnt    <= 6'd0;
            rx_state  <= R_DATA;
          end else if (rff == STOP_WORD) begin
            rx_opcode <= 4'hF;
            rx_valid  <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
        end
        R_DATA: begin
          for (int k = 0; k < RX_WORDS; k++)
            if (rx_cnt == 6'(k)) rx_data[k*EBI_WIDTH +: EBI_WIDTH] <= rff;
          rx_cnt <= rx_cnt + 6'd1;
          if (rx_cnt == rx_n - 6'd1) rx_state <= R_STOP;
        end
        R_STOP: begin
          if (rff == STOP_WORD) rx_valid <= 1'b1;
          else                  rx_err   <= 1'b1;
          rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inner_ebi_link.sv
// tb/tb_inner_ebi_link.sv - self-checking bench for inner_ebi_link against a frame-level model
module tb_inner_ebi_link;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  ebi_i = 16'hFFFF;
  logic [15:0]  ebi_o, ebi_oen;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [3:0]   tx_opcode = 4'd0;
  logic [559:0] tx_data = '0;
  logic         tx_done, rx_valid, rx_err, busy;
  logic [3:0]   rx_opcode;
  logic [527:0] rx_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0]  rxq[$];
  logic [3:0]   m_rx_opcode = 4'd0;
  logic [527:0] m_rx_data = '0;
  bit           m_known = 1'b1;

  inner_ebi_link dut (
    .clk(clk), .rst(rst), .ebi_o(ebi_o), .ebi_i(ebi_i), .ebi_oen(ebi_oen),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_opcode(tx_opcode), .tx_data(tx_data),
    .tx_done(tx_done), .rx_valid(rx_valid), .rx_opcode(rx_opcode), .rx_data(rx_data),
    .rx_err(rx_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [559:0] rand_payload();
    logic [559:0] r;
    for (int i = 0; i < 35; i++) r[16*i +: 16] = 16'($urandom);
    return r;
  endfunction

  // Frame-level expectation: start, opcode word, payload low word first, stop.
  task automatic run_tx_frame(input logic [3:0] op, input logic [559:0] data);
    logic [15:0] exp[$];
    int n, w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL tx_ready_wait op=%0h: tx_ready=%b after %0d cycles, required 1", op, tx_ready, w);
    end
    tx_valid = 1'b1; tx_opcode = op; tx_data = data;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0; tx_opcode = 4'($urandom); tx_data = rand_payload();
    case (op)
      4'd0: n = 4;
      4'd1: n = 35;
      4'd2: n = 3;
      4'd3: n = 32;
      4'd4: n = 0;
      default: n = -1;
    endcase
    if (n < 0) begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (ebi_oen !== 16'hFFFF || tx_done !== 1'b0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL tx_discard op=%0h cyc %0d: oen=%h done=%b busy=%b, required FFFF/0/0", op, i, ebi_oen, tx_done, busy);
        end
        @(negedge clk);
      end
    end else begin
      exp.push_back(16'hFFFE);
      exp.push_back({12'h000, op});
      for (int k = 0; k < n; k++) exp.push_back(data[16*k +: 16]);
      exp.push_back(16'hFFFF);
      foreach (exp[i]) begin
        if (i > 0) @(negedge clk);
        n_checks++;
        if (ebi_o !== exp[i] || ebi_oen !== 16'h0000 || tx_done !== 1'b0) begin
          n_fail++; $display("FAIL tx_word op=%0h idx %0d: ebi_o=%h oen=%h done=%b, required %h/0000/0", op, i, ebi_o, ebi_oen, tx_done, exp[i]);
        end
      end
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b1 || ebi_oen !== 16'hFFFF || ebi_o !== 16'hFFFF) begin
        n_fail++; $display("FAIL tx_done op=%0h: done=%b oen=%h ebi_o=%h, required 1/FFFF/FFFF", op, tx_done, ebi_oen, ebi_o);
      end
    end
  endtask

  // Drives rxq onto ebi_i one word per cycle and checks pulses against the frame rules.
  task automatic run_rx();
    int n, exp_v, exp_e, v_at, e_at, v_cnt, e_cnt;
    logic [15:0] opw;
    exp_v = -1; exp_e = -1; v_at = -1; e_at = -1; v_cnt = 0; e_cnt = 0;
    opw = rxq[1];
    if (opw == 16'hFFFF) begin
      exp_v = 3; m_rx_opcode = 4'hF;
    end else if (opw == 16'h0007 || opw == 16'h0006) begin
      n = (opw == 16'h0007) ? 33 : 3;
      m_rx_opcode = opw[3:0];
      if (rxq[2+n] == 16'hFFFF) begin
        exp_v = n + 4;
        m_rx_data = '0;
        for (int k = 0; k < n; k++) m_rx_data[16*k +: 16] = rxq[2+k];
        m_known = 1'b1;
      end else begin
        exp_e = n + 4;
        m_known = 1'b0;
      end
    end else begin
      exp_e = 3;
    end
    for (int i = 0; i < rxq.size() + 8; i++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin v_cnt++; v_at = i; end
      if (rx_err === 1'b1) begin e_cnt++; e_at = i; end
      ebi_i = (i < rxq.size()) ? rxq[i] : 16'hFFFF;
    end
    n_checks++;
    if (v_cnt !== ((exp_v >= 0) ? 1 : 0) || v_at !== exp_v) begin
      n_fail++; $display("FAIL rx_valid_timing op=%h: count=%0d at=%0d, required count=%0d at=%0d", opw, v_cnt, v_at, (exp_v >= 0) ? 1 : 0, exp_v);
    end
    n_checks++;
    if (e_cnt !== ((exp_e >= 0) ? 1 : 0) || e_at !== exp_e) begin
      n_fail++; $display("FAIL rx_err_timing op=%h: count=%0d at=%0d, required count=%0d at=%0d", opw, e_cnt, e_at, (exp_e >= 0) ? 1 : 0, exp_e);
    end
    n_checks++;
    if (rx_opcode !== m_rx_opcode) begin
      n_fail++; $display("FAIL rx_opcode: got %h, required %h", rx_opcode, m_rx_opcode);
    end
    if (exp_v >= 0 && m_known) begin
      n_checks++;
      if (rx_data !== m_rx_data) begin
        n_fail++; $display("FAIL rx_data: got %h required %h", rx_data, m_rx_data);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ebi_o !== 16'hFFFF || ebi_oen !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_pins: ebi_o=%h oen=%h, required FFFF/FFFF", ebi_o, ebi_oen);
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready);
    end
    n_checks++;
    if ({tx_done, rx_valid, rx_err, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: done/valid/err/busy=%b, required 0000", {tx_done, rx_valid, rx_err, busy});
    end
    n_checks++;
    if (rx_opcode !== 4'd0 || rx_data !== '0) begin
      n_fail++; $display("FAIL reset_rx_regs: opcode=%h data=%h, required 0/0", rx_opcode, rx_data);
    end
  endtask

  task automatic test_tx_dr();
    logic [559:0] d;
    d = '0;
    d[63:0] = 64'h0003_0001_8000_1040;
    run_tx_frame(4'd0, d);
    @(negedge clk);
    n_checks++;
    if (tx_done !== 1'b0 || ebi_oen !== 16'hFFFF) begin
      n_fail++; $display("FAIL tx_dr_after: done=%b oen=%h, required 0/FFFF", tx_done, ebi_oen);
    end
  endtask

  task automatic test_tx_random();
    repeat (6) run_tx_frame(4'($urandom_range(0, 4)), rand_payload());
  endtask

  task automatic test_back_to_back();
    run_tx_frame(4'd2, rand_payload());
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_in_done_cycle: got %b, required 1", tx_ready);
    end
    run_tx_frame(4'd3, rand_payload());
  endtask

  task automatic test_rx_rd_resp();
    rxq.delete();
    rxq.push_back(16'hFFFE); rxq.push_back(16'h0007);
    for (int i = 0; i < 32; i++) rxq.push_back(16'h0100 + 16'(i));
    rxq.push_back(16'h0002); rxq.push_back(16'hFFFF);
    run_rx();
    n_checks++;
    if (rx_data[15:0] !== 16'h0100 || rx_data[511:496] !== 16'h011F || rx_data[527:512] !== 16'h0002) begin
      n_fail++; $display("FAIL rd_resp_words: w0=%h w31=%h mesi=%h, required 0100/011F/0002", rx_data[15:0], rx_data[511:496], rx_data[527:512]);
    end
  endtask

  task automatic test_rx_ack_snp();
    rxq = '{16'hFFFE, 16'hFFFF};
    run_rx();
    rxq = '{16'hFFFE, 16'h0006, 16'h1000, 16'h8000, 16'h0005, 16'hFFFF};
    run_rx();
    n_checks++;
    if (rx_data[47:0] !== 48'h0005_8000_1000 || rx_data[527:48] !== '0) begin
      n_fail++; $display("FAIL snp_req_data: got %h, required 0005_8000_1000 with zero upper bits", rx_data);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    ebi_i = 16'hFFFE;
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL collision_ready: got %b, required 0", tx_ready);
    end
    tx_valid = 1'b1; tx_opcode = 4'h4; tx_data = rand_payload(); ebi_i = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if (ebi_oen !== 16'hFFFF || tx_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL collision_rx_wins: oen=%h ready=%b busy=%b, required FFFF/0/1", ebi_oen, tx_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b1 || rx_opcode !== 4'hF || ebi_oen !== 16'hFFFF) begin
      n_fail++; $display("FAIL collision_ack: valid=%b op=%h oen=%h, required 1/F/FFFF", rx_valid, rx_opcode, ebi_oen);
    end
    m_rx_opcode = 4'hF;
    run_tx_frame(4'h4, tx_data);
  endtask

  task automatic test_errors();
    rxq = '{16'hFFFE, 16'h0005};
    run_rx();
    rxq = '{16'hFFFE, 16'h0006, 16'h1234, 16'h5679, 16'h0001, 16'h7FFF};
    run_rx();
    run_tx_frame(4'h9, rand_payload());
  endtask

  task automatic test_rx_random();
    int sel, n;
    repeat (5) begin
      sel = $urandom_range(0, 2);
      rxq.delete();
      rxq.push_back(16'hFFFE);
      if (sel == 0) begin
        rxq.push_back(16'hFFFF);
      end else begin
        n = (sel == 1) ? 33 : 3;
        rxq.push_back((sel == 1) ? 16'h0007 : 16'h0006);
        repeat (n) rxq.push_back(16'($urandom));
        rxq.push_back(16'hFFFF);
      end
      run_rx();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [559:0] d;
    int dones;
    d = rand_payload();
    @(negedge clk);
    tx_valid = 1'b1; tx_opcode = 4'd1; tx_data = d;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ebi_o !== d[175:160] || ebi_oen !== 16'h0000) begin
      n_fail++; $display("FAIL midframe_word10: ebi_o=%h oen=%h, required %h/0000", ebi_o, ebi_oen, d[175:160]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ebi_oen !== 16'hFFFF || ebi_o !== 16'hFFFF || tx_done !== 1'b0) begin
      n_fail++; $display("FAIL midframe_async_release: oen=%h ebi_o=%h done=%b, required FFFF/FFFF/0", ebi_oen, ebi_o, tx_done);
    end
    m_rx_opcode = 4'd0; m_rx_data = '0; m_known = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0 || tx_ready !== 1'b1 || ebi_oen !== 16'hFFFF) begin
      n_fail++; $display("FAIL midframe_after: dones=%0d ready=%b oen=%h, required 0/1/FFFF", dones, tx_ready, ebi_oen);
    end
    n_checks++;
    if (rx_opcode !== m_rx_opcode || rx_data !== m_rx_data) begin
      n_fail++; $display("FAIL midframe_rx_regs: opcode=%h, required %h", rx_opcode, m_rx_opcode);
    end
  endtask

  initial begin
    test_reset();
    test_tx_dr();
    test_tx_random();
    test_back_to_back();
    test_rx_rd_resp();
    test_rx_ack_snp();
    test_collision();
    test_errors();
    test_rx_random();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inner_ebi_link.md
# inner_ebi_link

On-chip (cache-side) end of the external bus interface (EBI) link. It serializes outgoing read/write requests and snoop responses onto the 16-bit half-duplex EBI pins, and deserializes incoming read responses, snoop requests and write acks from the memory-side transceiver. It owns its own TX and RX state machines, so the cache-side controller sees a plain valid/ready request port and a pulsed receive port.

## Interface
- EBI_WIDTH, 16, pin/word width
- PADDR_WIDTH, 32, physical address bits (2 words)
- CACHELINE_LENGTH, 512, line bits (32 words)
- TX_BUF_LENGTH, PADDR_WIDTH+EBI_WIDTH+CACHELINE_LENGTH (560), max TX payload
- RX_BUF_LENGTH, CACHELINE_LENGTH+EBI_WIDTH (528), max RX payload

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- ebi_o  out  EBI_WIDTH  pin output data
- ebi_i  in  EBI_WIDTH  pin input data
- ebi_oen  out  EBI_WIDTH  output enable, active-low per bit; all ones = receiving
- tx_valid / tx_ready  in / out  1  request handshake
- tx_opcode  in  4  0 DR, 1 DW1 (with data), 2 DW2 (no data), 3 SNP_RESP1 (with data), 4 SNP_RESP2
- tx_data  in  TX_BUF_LENGTH  payload; word k = tx_data[16k +: 16]
- tx_done  out  1  one-cycle pulse, frame fully sent
- rx_valid  out  1  one-cycle pulse, frame received
- rx_opcode  out  4  opcode of last received frame
- rx_data  out  RX_BUF_LENGTH  payload of last frame, word k at [16k +: 16]
- rx_err  out  1  one-cycle pulse, bad opcode or bad stop word
- busy  out  1  TX or RX state not idle

## Operation
- Frame: start word 16'hFFFE (bit0=0), opcode word {12'h000, op}, N payload words low word first, stop word 16'hFFFF. Idle bus is all ones.
- TX payload N: DR 4 (addr lo, addr hi, arsnoop, id), DW1 35 (addr 2, arsnoop 1, line 32), DW2 3, SNP_RESP1 32, SNP_RESP2 0.
- RX payload N: RD_RESP (7) 33 (line 32, then MESI word at bits [527:512]), SNP_REQ (6) 3 (addr 2, snoop 1), ACK (F) 0. ACK is start followed directly by the stop word; its opcode word is the stop word.
- Input sync: rff <= ebi_i every edge, reset to all ones. RX logic sees rff only.
- tx_ready = TX idle & RX idle & rff[0]==1. On accept, tx_opcode/tx_data are captured; later changes are ignored. tx_opcode 5..15 is accepted and discarded: no bus activity, no tx_done.
- TX FSM: T_IDLE -> T_START -> T_OP -> T_DATA (N words, 6-bit counter, skipped if N=0) -> T_STOP -> T_IDLE. ebi_o/ebi_oen registered. ebi_oen = 0 in START..STOP, all ones otherwise.
- RX FSM: R_IDLE -> (rff[0]==0 and TX idle) R_OP. R_OP: 7/6 -> clear rx buffer, R_DATA; F -> rx_valid; other -> rx_err, R_IDLE. R_DATA stores rff at word counter until N words -> R_STOP. R_STOP: rff==16'hFFFF -> rx_valid, else rx_err; -> R_IDLE.
- rx_opcode/rx_data hold until the next valid frame's R_OP; on rx_err, rx_data content is undefined but rx_opcode holds.
- While TX not idle, RX ignores rff (own echo).
- No resync after rx_err: a payload word with bit0=0 may start a false frame, which ends in rx_err.

## Timing
- Reset: ebi_o all ones, ebi_oen all ones, tx_ready 1 (after rff reset to ones), tx_done/rx_valid/rx_err/busy 0, rx_opcode 0, rx_data 0. Reset mid-frame releases pins immediately; the frame is not completed and no tx_done is generated.
- TX: accept at edge T; start word is driven in cycle T+1, stop word in cycle T+N+3, and tx_done is high in cycle T+N+4 with ebi_oen back to all ones. A new request may be accepted in the tx_done cycle.
- RX: start word on ebi_i in cycle t -> rx_valid in cycle t+N+4 (ACK: t+3; RD_RESP: t+37).
- Collision: start word in rff in the same cycle as tx_valid -> RX wins, tx_ready 0; TX may start once RX returns idle.

## Test plan
- DR tx, tx_data[63:0]=64'h0003_0001_8000_1040 -> ebi_o FFFE,0000,1040,8000,0001,0003,FFFF with ebi_oen=0 for those 7 cycles; tx_done 1 cycle later; then ebi_oen=FFFF.
- RD_RESP rx: FFFE, 0007, words 0100+i (i=0..31), 0002, FFFF -> single rx_valid, rx_opcode=7, rx_data[15:0]=0100, rx_data[511:496]=011F, rx_data[527:512]=0002.
- ACK rx: FFFE then FFFF -> rx_valid 3 cycles after start, rx_opcode=F; then SNP_REQ FFFE,0006,1000,8000,0005,FFFF -> rx_data[47:0]=48'h0005_8000_1000, upper bits 0.
- Collision: SNP_RESP2 tx_valid in the same cycle an ACK start reaches rff -> ACK rx_valid first; then ebi_o FFFE,0004,FFFF, tx_done.
- Errors: rx opcode 0005 -> rx_err, no rx_valid; SNP_REQ with stop word 7FFF -> rx_err; tx_opcode 9 -> accepted, no ebi_oen activity, no tx_done.
- Async reset while DW1 payload word 10 is on the pins -> ebi_oen=FFFF within the same cycle, no tx_done; tx_ready=1 after release.
